// File: rtl/battleship_pkg.sv
// Shared types and constants for the ship-placement accelerator front end.
// Holds the ship table entry type, update_ship word slot layout and sequencer states.
`timescale 1ns/1ps
package battleship_pkg;

  localparam int         NUM_SHIPS    = 5;
  localparam logic [2:0] NO_SHIP_TYPE = 3'b111;

  // Slot layout inside a 32-bit update_ship word; bits [9:0] are always zero.
  localparam int UPPER_POS_LSB  = 25;
  localparam int UPPER_VERT_BIT = 24;
  localparam int UPPER_TYPE_LSB = 21;
  localparam int LOWER_POS_LSB  = 14;
  localparam int LOWER_VERT_BIT = 13;
  localparam int LOWER_TYPE_LSB = 10;

  typedef struct packed {
    logic [6:0] pos;
    logic       vert;
  } ship_entry_t;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_LOAD0,
    SEQ_LOAD1,
    SEQ_LOAD2,
    SEQ_START,
    SEQ_DONE
  } seq_state_e;

endpackage

// File: rtl/accel_sequencer_if.sv
// CPU-side and accelerator-side signals of the sequencer, bundled as one interface.
// slave = the sequencer; master = the CPU and accelerator it talks to.
`timescale 1ns/1ps
interface accel_sequencer_if;

  logic        ship_wr;
  logic [2:0]  ship_type;
  logic [6:0]  ship_pos;
  logic        ship_vert;
  logic        ship_ready;
  logic        clear;
  logic        check_req;
  logic [31:0] acc_data;
  logic        acc_update_ship;
  logic        acc_start;
  logic        acc_valid;
  logic        result_valid;
  logic        result_ok;
  logic        result_missing;
  logic        result_ack;
  logic        busy;

  modport slave (
    input  ship_wr, ship_type, ship_pos, ship_vert, clear, check_req, acc_valid, result_ack,
    output ship_ready, acc_data, acc_update_ship, acc_start,
           result_valid, result_ok, result_missing, busy
  );

  modport master (
    output ship_wr, ship_type, ship_pos, ship_vert, clear, check_req, acc_valid, result_ack,
    input  ship_ready, acc_data, acc_update_ship, acc_start,
           result_valid, result_ok, result_missing, busy
  );

endinterface

// File: rtl/accel_word_packer.sv
// Packs two ship entries with their type codes into one update_ship word.
`timescale 1ns/1ps
module accel_word_packer
  import battleship_pkg::*;
(
  input  ship_entry_t hi,
  input  logic [2:0]  hi_type,
  input  ship_entry_t lo,
  input  logic [2:0]  lo_type,
  output logic [31:0] word
);

  // NOTE: every bit gets a default before the slot fields so no latch is inferred.
  always_comb begin
    word                          = '0;
    word[UPPER_POS_LSB +: 7]      = hi.pos;
    word[UPPER_VERT_BIT]          = hi.vert;
    word[UPPER_TYPE_LSB +: 3]     = hi_type;
    word[LOWER_POS_LSB +: 7]      = lo.pos;
    word[LOWER_VERT_BIT]          = lo.vert;
    word[LOWER_TYPE_LSB +: 3]     = lo_type;
  end

endmodule

// File: rtl/accel_sequencer.sv
// Collects five ship placements, streams them to the accelerator as three
// update_ship words, runs the start window and holds the verdict until acked.
`timescale 1ns/1ps
module accel_sequencer
  import battleship_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input logic              clk,
  input logic              rst_n,
  accel_sequencer_if.slave bus
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  seq_state_e                  state, state_next;
  ship_entry_t [NUM_SHIPS-1:0] ships, ships_d;
  logic [NUM_SHIPS-1:0]        mask, mask_d;
  logic [CW-1:0]               cnt, cnt_d;

  ship_entry_t hi, lo;
  logic [2:0]  hi_type, lo_type;
  logic [31:0] packed_word;

  logic [31:0] data_d;
  logic        update_d, start_d, valid_d, ok_d, missing_d, busy_d, ready_d;

  // Table writes are only honoured in IDLE; clear beats a simultaneous write.
  always_comb begin
    ships_d = ships;
    mask_d  = mask;
    if (state == SEQ_IDLE) begin
      if (bus.clear) begin
        mask_d = '0;
      end else if (bus.ship_wr) begin
        for (int i = 0; i < NUM_SHIPS; i++) begin
          if (bus.ship_type == 3'(i)) begin
            ships_d[i] = '{pos: bus.ship_pos, vert: bus.ship_vert};
            mask_d[i]  = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: entries are not reset; the mask alone says which ones are meaningful.
  always_ff @(posedge clk) begin
    ships <= ships_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEQ_IDLE;
      mask  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      mask  <= mask_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_next = state;
    cnt_d      = cnt;
    case (state)
      SEQ_IDLE:  if (bus.check_req) state_next = (&mask_d) ? SEQ_LOAD0 : SEQ_DONE;
      SEQ_LOAD0: state_next = SEQ_LOAD1;
      SEQ_LOAD1: state_next = SEQ_LOAD2;
      SEQ_LOAD2: begin
        state_next = SEQ_START;
        cnt_d      = CW'(SETTLE_CYCLES - 1);
      end
      SEQ_START: begin
        if (cnt == '0) state_next = SEQ_DONE;
        else           cnt_d      = cnt - 1'b1;
      end
      SEQ_DONE:  if (bus.result_ack) state_next = SEQ_IDLE;
      default:   state_next = SEQ_IDLE;
    endcase
  end

  // Outputs are computed for the upcoming state and registered, so they line up with it.
  always_comb begin
    hi      = ships_d[4];
    hi_type = 3'd4;
    lo      = '0;
    lo_type = NO_SHIP_TYPE;
    case (state_next)
      SEQ_LOAD0: begin hi = ships_d[0]; hi_type = 3'd0; lo = ships_d[1]; lo_type = 3'd1; end
      SEQ_LOAD1: begin hi = ships_d[2]; hi_type = 3'd2; lo = ships_d[3]; lo_type = 3'd3; end
      default: ;
    endcase
  end

  accel_word_packer u_packer (
    .hi      (hi),
    .hi_type (hi_type),
    .lo      (lo),
    .lo_type (lo_type),
    .word    (packed_word)
  );

  always_comb begin
    data_d    = '0;
    update_d  = 1'b0;
    start_d   = 1'b0;
    valid_d   = 1'b0;
    ok_d      = bus.result_ok;
    missing_d = bus.result_missing;
    case (state_next)
      SEQ_LOAD0, SEQ_LOAD1, SEQ_LOAD2: begin
        data_d   = packed_word;
        update_d = 1'b1;
      end
      SEQ_START: start_d = 1'b1;
      SEQ_DONE:  valid_d = 1'b1;
      default: ;
    endcase
    if (state == SEQ_IDLE && state_next == SEQ_DONE) begin
      ok_d      = 1'b0;
      missing_d = 1'b1;
    end
    if (state == SEQ_START && state_next == SEQ_DONE) begin
      ok_d      = bus.acc_valid;
      missing_d = 1'b0;
    end
    if (state_next == SEQ_IDLE) begin
      ok_d      = 1'b0;
      missing_d = 1'b0;
    end
    busy_d  = (state_next != SEQ_IDLE);
    ready_d = (state_next == SEQ_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.acc_data        <= '0;
      bus.acc_update_ship <= 1'b0;
      bus.acc_start       <= 1'b0;
      bus.result_valid    <= 1'b0;
      bus.result_ok       <= 1'b0;
      bus.result_missing  <= 1'b0;
      bus.busy            <= 1'b0;
      bus.ship_ready      <= 1'b1;
    end else begin
      bus.acc_data        <= data_d;
      bus.acc_update_ship <= update_d;
      bus.acc_start       <= start_d;
      bus.result_valid    <= valid_d;
      bus.result_ok       <= ok_d;
      bus.result_missing  <= missing_d;
      bus.busy            <= busy_d;
      bus.ship_ready      <= ready_d;
    end
  end

endmodule

// File: tb/tb_accel_sequencer.sv
// Self-checking bench for accel_sequencer: directed scenarios plus randomized
// placements, checked against a ship-table / word-packing reference model.
`timescale 1ns/1ps
module tb_accel_sequencer;

  localparam int S = 2;

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference model of the CPU-visible ship table
  int       m_pos  [5];
  bit       m_vert [5];
  bit [4:0] m_mask;

  accel_sequencer_if bus ();

  accel_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] slot(input int pos, input bit vert, input int typ, input bit upper);
    logic [31:0] p, v, t;
    int          base;
    base = upper ? 21 : 10;
    p = 32'(pos);
    v = 32'(vert);
    t = 32'(typ);
    return (p << (base + 4)) | (v << (base + 3)) | (t << base);
  endfunction

  function automatic logic [31:0] exp_word(input int k);
    case (k)
      0:       return slot(m_pos[0], m_vert[0], 0, 1) | slot(m_pos[1], m_vert[1], 1, 0);
      1:       return slot(m_pos[2], m_vert[2], 2, 1) | slot(m_pos[3], m_vert[3], 3, 0);
      default: return slot(m_pos[4], m_vert[4], 4, 1) | slot(0, 1'b0, 7, 0);
    endcase
  endfunction

  task automatic model_write(input int t, input int pos, input bit vert);
    if (t < 5) begin
      m_pos[t]  = pos;
      m_vert[t] = vert;
      m_mask[t] = 1'b1;
    end
  endtask

  task automatic write_ship(input int t, input int pos, input bit vert);
    bus.ship_wr   = 1'b1;
    bus.ship_type = 3'(t);
    bus.ship_pos  = 7'(pos);
    bus.ship_vert = vert;
    model_write(t, pos, vert);
    tick();
    bus.ship_wr = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    m_mask    = '0;
    tick();
    bus.clear = 1'b0;
  endtask

  // One complete check from check_req to the cycle after the ack.
  task automatic do_check(input bit v_last, input int ack_delay, input bit disturb,
                          input bit wr_en, input int wr_type, input int wr_pos,
                          input bit wr_vert, input bit clr);
    bit full;
    bus.check_req = 1'b1;
    bus.ship_wr   = wr_en;
    bus.ship_type = 3'(wr_type);
    bus.ship_pos  = 7'(wr_pos);
    bus.ship_vert = wr_vert;
    bus.clear     = clr;
    if (clr)        m_mask = '0;
    else if (wr_en) model_write(wr_type, wr_pos, wr_vert);
    full = (m_mask == 5'h1f);
    tick();
    bus.check_req = 1'b0;
    bus.ship_wr   = 1'b0;
    bus.clear     = 1'b0;
    if (full) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("update_ship_c%0d", k + 1), bus.acc_update_ship, 1);
        check($sformatf("word%0d", k), bus.acc_data, exp_word(k));
        check($sformatf("start_low_c%0d", k + 1), bus.acc_start, 0);
        check($sformatf("busy_c%0d", k + 1), bus.busy, 1);
        check($sformatf("rv_low_c%0d", k + 1), bus.result_valid, 0);
        if (disturb && k == 0) begin
          bus.ship_wr   = 1'b1;
          bus.ship_type = 3'd2;
          bus.ship_pos  = 7'd99;
          bus.ship_vert = 1'b1;
        end
        if (disturb && k == 1) begin
          bus.ship_wr   = 1'b1;
          bus.ship_type = 3'd6;
          bus.ship_pos  = 7'd5;
          bus.clear     = 1'b1;
        end
        tick();
        bus.ship_wr = 1'b0;
        bus.clear   = 1'b0;
      end
      for (int s = 0; s < S; s++) begin
        check($sformatf("start_c%0d", 4 + s), bus.acc_start, 1);
        check($sformatf("update_low_c%0d", 4 + s), bus.acc_update_ship, 0);
        bus.acc_valid = (s == S - 1) ? v_last : 1'($urandom);
        if (disturb) bus.check_req = 1'b1;
        tick();
        bus.check_req = 1'b0;
      end
      bus.acc_valid = 1'b0;
      check("rv_done", bus.result_valid, 1);
      check("result_ok", bus.result_ok, 32'(v_last));
      check("missing_low", bus.result_missing, 0);
      check("start_low_done", bus.acc_start, 0);
    end else begin
      check("rv_missing_c1", bus.result_valid, 1);
      check("result_missing", bus.result_missing, 1);
      check("ok_low_missing", bus.result_ok, 0);
      check("no_update_missing", bus.acc_update_ship, 0);
      check("no_start_missing", bus.acc_start, 0);
      check("busy_missing", bus.busy, 1);
    end
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      check("rv_held", bus.result_valid, 1);
      check("busy_held", bus.busy, 1);
    end
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    check("rv_drop_after_ack", bus.result_valid, 0);
    check("busy_drop_after_ack", bus.busy, 0);
    check("ready_after_ack", bus.ship_ready, 1);
    tick();
    check("no_restart_busy", bus.busy, 0);
    check("no_restart_update", bus.acc_update_ship, 0);
  endtask

  initial begin
    bus.ship_wr    = 1'b0;
    bus.ship_type  = '0;
    bus.ship_pos   = '0;
    bus.ship_vert  = 1'b0;
    bus.clear      = 1'b0;
    bus.check_req  = 1'b0;
    bus.acc_valid  = 1'b0;
    bus.result_ack = 1'b0;
    m_mask         = '0;
    for (int i = 0; i < 5; i++) begin
      m_pos[i]  = 0;
      m_vert[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.ship_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_data", bus.acc_data, 0);
    check("rst_update", bus.acc_update_ship, 0);
    check("rst_start", bus.acc_start, 0);
    check("rst_rv", bus.result_valid, 0);
    check("rst_ok", bus.result_ok, 0);
    check("rst_missing", bus.result_missing, 0);
    rst_n = 1'b1;
    tick();

    // Reference placement, accelerator reports legal
    for (int i = 0; i < 5; i++) write_ship(i, 20 * i, 1'b0);
    do_check(1'b1, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    // Same placement, acc_valid low only on the last start cycle
    do_check(1'b0, 1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Only ships 0-3 present
    do_clear();
    for (int i = 0; i < 4; i++) write_ship(i, 10 + i, 1'b1);
    do_check(1'b1, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Ship 4 written in the same cycle as check_req completes the table
    do_check(1'b1, 2, 1'b0, 1'b1, 4, 88, 1'b1, 1'b0);

    // Writes, clear and check_req while busy are ignored
    do_check(1'b1, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    do_check(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Long hold before ack
    do_check(1'b1, 10, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Clear beats a simultaneous write: ship 0 stays absent
    bus.ship_wr   = 1'b1;
    bus.ship_type = 3'd0;
    bus.ship_pos  = 7'd7;
    bus.clear     = 1'b1;
    m_mask        = '0;
    tick();
    bus.ship_wr = 1'b0;
    bus.clear   = 1'b0;
    for (int i = 1; i < 5; i++) write_ship(i, 30 + i, 1'b0);
    do_check(1'b1, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of LOAD1
    for (int i = 0; i < 5; i++) write_ship(i, $urandom_range(0, 99), 1'($urandom));
    bus.check_req = 1'b1;
    tick();
    bus.check_req = 1'b0;
    tick();
    check("load1_before_reset", bus.acc_update_ship, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_data", bus.acc_data, 0);
    check("mid_rst_update", bus.acc_update_ship, 0);
    check("mid_rst_start", bus.acc_start, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_rv", bus.result_valid, 0);
    check("mid_rst_ready", bus.ship_ready, 1);
    m_mask = '0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle_update", bus.acc_update_ship, 0);
    do_check(1'b1, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Randomized placements, including discarded types and coinciding writes/clears
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 3) == 0) do_clear();
      for (int w = 0; w < 8; w++)
        write_ship($urandom_range(0, 7), $urandom_range(0, 127), 1'($urandom));
      do_check(1'($urandom), $urandom_range(0, 3), 1'($urandom),
               1'($urandom), $urandom_range(0, 7), $urandom_range(0, 127),
               1'($urandom), ($urandom_range(0, 5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
